// File: rtl/sample_iter_if.sv
// Handshake bundle between the bounding-box stage, the sample iterator and the sample-test stage.
// Optional SAMPLE_ITER_COUNT_EN adds the per-triangle sample counter and done pulse.
interface sample_iter_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed   [SIGFIG-1:0] tri_R13S   [VERTS][AXIS];
  logic          [SIGFIG-1:0] color_R13U [COLORS];
  logic signed   [SIGFIG-1:0] box_R13S   [2][2];
  logic                       validTri_R13H;
  logic signed   [SIGFIG-1:0] step_R13S;
  logic                       stall_R14H;
  logic                       halt_RnnnnL;
  logic signed   [SIGFIG-1:0] tri_R14S   [VERTS][AXIS];
  logic          [SIGFIG-1:0] color_R14U [COLORS];
  logic signed   [SIGFIG-1:0] sample_R14S [2];
  logic                       validSamp_R14H;
`ifdef SAMPLE_ITER_COUNT_EN
  logic          [15:0]       count_R14U;
  logic                       done_R14H;
`endif

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, step_R13S, stall_R14H,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SAMPLE_ITER_COUNT_EN
    , input count_R14U, done_R14H
`endif
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, step_R13S, stall_R14H,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
`ifdef SAMPLE_ITER_COUNT_EN
    , output count_R14U, done_R14H
`endif
  );
endinterface

// File: rtl/sample_iter_ctrl.sv
// Walks every sample position of a triangle's bounding box in raster order, one per cycle.
// Define SAMPLE_ITER_COUNT_EN to add count_R14U / done_R14H.
module sample_iter_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic            clk,
  input  logic            rst,
  sample_iter_if.slave    bus
);

  // Positions are compared as raw fixed-point integers, so RADIX only names the format.
  if (RADIX < 0 || RADIX >= SIGFIG) begin : g_radix_out_of_range
  end

  typedef enum logic {WAIT, TEST} state_t;

  state_t                     state;
  logic signed [SIGFIG-1:0]   tri_p1    [VERTS][AXIS];
  logic        [SIGFIG-1:0]   color_p1  [COLORS];
  logic signed [SIGFIG-1:0]   sample_p1 [2];
  logic signed [SIGFIG-1:0]   llx_p1, urx_p1, ury_p1, step_p1;
  logic                       vld_p1;

  logic signed [SIGFIG:0]     nx, ny, urx_ext, ury_ext;
  logic                       x_over, y_over, last, halt, accept, advance;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One extra bit keeps x+step / y+step from wrapping near the top of the range.
  always_comb begin
    nx      = {sample_p1[0][SIGFIG-1], sample_p1[0]} + {step_p1[SIGFIG-1], step_p1};
    ny      = {sample_p1[1][SIGFIG-1], sample_p1[1]} + {step_p1[SIGFIG-1], step_p1};
    urx_ext = {urx_p1[SIGFIG-1], urx_p1};
    ury_ext = {ury_p1[SIGFIG-1], ury_p1};
    x_over  = nx > urx_ext;
    y_over  = ny > ury_ext;
    last    = x_over && y_over;
    advance = (state == TEST) && !bus.stall_R14H;
    halt    = (state == WAIT) || (advance && last);
    accept  = bus.validTri_R13H && halt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT;
      vld_p1    <= 1'b0;
      tri_p1    <= '{default: '0};
      color_p1  <= '{default: '0};
      sample_p1 <= '{default: '0};
      llx_p1    <= '0;
      urx_p1    <= '0;
      ury_p1    <= '0;
      step_p1   <= '0;
    end else if (accept) begin
      state        <= TEST;
      vld_p1       <= 1'b1;
      tri_p1       <= bus.tri_R13S;
      color_p1     <= bus.color_R13U;
      sample_p1[0] <= bus.box_R13S[0][0];
      sample_p1[1] <= bus.box_R13S[0][1];
      llx_p1       <= bus.box_R13S[0][0];
      urx_p1       <= bus.box_R13S[1][0];
      ury_p1       <= bus.box_R13S[1][1];
      step_p1      <= bus.step_R13S;
    end else if (advance) begin
      if (last) begin
        state  <= WAIT;
        vld_p1 <= 1'b0;
      end else if (!x_over) begin
        sample_p1[0] <= nx[SIGFIG-1:0];
      end else begin
        sample_p1[0] <= llx_p1;
        sample_p1[1] <= ny[SIGFIG-1:0];
      end
    end
  end

`ifdef SAMPLE_ITER_COUNT_EN
  logic [15:0] count_p1;
  logic        done_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1 <= '0;
      done_p1  <= 1'b0;
    end else begin
      done_p1 <= advance && last;
      if (accept)
        count_p1 <= '0;
      else if (advance)
        count_p1 <= sat_inc16(count_p1);
    end
  end

  assign bus.count_R14U = count_p1;
  assign bus.done_R14H  = done_p1;
`endif

  assign bus.halt_RnnnnL    = halt;
  assign bus.tri_R14S       = tri_p1;
  assign bus.color_R14U     = color_p1;
  assign bus.sample_R14S    = sample_p1;
  assign bus.validSamp_R14H = vld_p1;

endmodule

// File: tb/tb_sample_iter_ctrl.sv
// Directed bench for sample_iter_ctrl; count/done checks build only with SAMPLE_ITER_COUNT_EN.
module tb_sample_iter_ctrl;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sample_iter_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) bus ();

  sample_iter_ctrl #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_tri(input int base, input int llx, input int lly,
                          input int urx, input int ury, input int stp);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        bus.tri_R13S[v][a] = SIGFIG'(base + v * 4 + a);
    for (int c = 0; c < COLORS; c++)
      bus.color_R13U[c] = SIGFIG'(base + 100 + c);
    bus.box_R13S[0][0] = SIGFIG'(llx);
    bus.box_R13S[0][1] = SIGFIG'(lly);
    bus.box_R13S[1][0] = SIGFIG'(urx);
    bus.box_R13S[1][1] = SIGFIG'(ury);
    bus.step_R13S      = SIGFIG'(stp);
    bus.validTri_R13H  = 1'b1;
  endtask

  task automatic expect_samp(input string tag, input int x, input int y,
                             input logic halt_exp, input logic stall);
    bus.stall_R14H = stall;
    #1;
    check({tag, " valid"}, bus.validSamp_R14H, 1);
    check({tag, " x"}, bus.sample_R14S[0], x);
    check({tag, " y"}, bus.sample_R14S[1], y);
    check({tag, " halt"}, bus.halt_RnnnnL, halt_exp);
    tick();
  endtask

  initial begin
    bus.validTri_R13H = 1'b0;
    bus.stall_R14H    = 1'b0;
    load_tri(0, 0, 0, 0, 0, 0);
    bus.validTri_R13H = 1'b0;

    // reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst valid", bus.validSamp_R14H, 0);
    check("rst halt", bus.halt_RnnnnL, 1);
    check("rst x", bus.sample_R14S[0], 0);
    check("rst y", bus.sample_R14S[1], 0);
    check("rst tri", bus.tri_R14S[2][1], 0);
`ifdef SAMPLE_ITER_COUNT_EN
    check("rst count", bus.count_R14U, 0);
    check("rst done", bus.done_R14H, 0);
`endif

    // 3x2 box, no stall
    load_tri(10, 0, 0, 2048, 1024, 1024);
    tick();
    bus.validTri_R13H = 1'b0;
    check("t2 tri", bus.tri_R14S[2][1], 19);
    check("t2 color", bus.color_R14U[1], 111);
    expect_samp("t2 s0", 0,    0,    1'b0, 1'b0);
    expect_samp("t2 s1", 1024, 0,    1'b0, 1'b0);
    expect_samp("t2 s2", 2048, 0,    1'b0, 1'b0);
    expect_samp("t2 s3", 0,    1024, 1'b0, 1'b0);
    expect_samp("t2 s4", 1024, 1024, 1'b0, 1'b0);
    expect_samp("t2 s5", 2048, 1024, 1'b1, 1'b0);
    check("t2 end valid", bus.validSamp_R14H, 0);
    check("t2 end halt", bus.halt_RnnnnL, 1);

    // same box, stall on 2nd and 3rd sample cycles
    load_tri(20, 0, 0, 2048, 1024, 1024);
    tick();
    bus.validTri_R13H = 1'b0;
    expect_samp("t3 c0", 0,    0,    1'b0, 1'b0);
    expect_samp("t3 c1", 1024, 0,    1'b0, 1'b1);
    expect_samp("t3 c2", 1024, 0,    1'b0, 1'b1);
    expect_samp("t3 c3", 1024, 0,    1'b0, 1'b0);
    expect_samp("t3 c4", 2048, 0,    1'b0, 1'b0);
    expect_samp("t3 c5", 0,    1024, 1'b0, 1'b0);
    expect_samp("t3 c6", 1024, 1024, 1'b0, 1'b0);
    expect_samp("t3 c7", 2048, 1024, 1'b1, 1'b0);
    check("t3 end valid", bus.validSamp_R14H, 0);

    // back-to-back triangles, validTri held high
    load_tri(30, -1024, -1024, 0, -1024, 1024);
    tick();
    load_tri(40, 512, 512, 512, 512, 1024);
    check("t4 tri A", bus.tri_R14S[2][1], 39);
    expect_samp("t4 s0", -1024, -1024, 1'b0, 1'b0);
    expect_samp("t4 s1", 0,     -1024, 1'b1, 1'b0);
    check("t4 tri B", bus.tri_R14S[2][1], 49);
    check("t4 color B", bus.color_R14U[2], 142);
    bus.validTri_R13H = 1'b0;
    expect_samp("t4 s2", 512, 512, 1'b1, 1'b0);
    check("t4 end valid", bus.validSamp_R14H, 0);

    // degenerate box
    load_tri(50, 2048, 0, 1024, 0, 1024);
    tick();
    bus.validTri_R13H = 1'b0;
    expect_samp("t5 s0", 2048, 0, 1'b1, 1'b0);
    check("t5 end valid", bus.validSamp_R14H, 0);
    check("t5 end halt", bus.halt_RnnnnL, 1);

    // reset during iteration of a 4x4 box
    load_tri(60, 0, 0, 3072, 3072, 1024);
    tick();
    bus.validTri_R13H = 1'b0;
    expect_samp("t6 s0", 0,    0, 1'b0, 1'b0);
    expect_samp("t6 s1", 1024, 0, 1'b0, 1'b0);
    check("t6 s2 x", bus.sample_R14S[0], 2048);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 rst valid", bus.validSamp_R14H, 0);
    check("t6 rst halt", bus.halt_RnnnnL, 1);
    check("t6 rst x", bus.sample_R14S[0], 0);
    check("t6 rst tri", bus.tri_R14S[2][1], 0);
    load_tri(70, -2048, 4096, -1024, 4096, 1024);
    tick();
    bus.validTri_R13H = 1'b0;
    expect_samp("t6 n0", -2048, 4096, 1'b0, 1'b0);
    expect_samp("t6 n1", -1024, 4096, 1'b1, 1'b0);
    check("t6 end valid", bus.validSamp_R14H, 0);

`ifdef SAMPLE_ITER_COUNT_EN
    // sample counter and done pulse on a 2x2 box
    load_tri(80, 0, 0, 1024, 1024, 1024);
    tick();
    bus.validTri_R13H = 1'b0;
    check("t7 count0", bus.count_R14U, 0);
    check("t7 done0", bus.done_R14H, 0);
    expect_samp("t7 s0", 0, 0, 1'b0, 1'b0);
    check("t7 count1", bus.count_R14U, 1);
    check("t7 done1", bus.done_R14H, 0);
    expect_samp("t7 s1", 1024, 0, 1'b0, 1'b0);
    check("t7 count2", bus.count_R14U, 2);
    check("t7 done2", bus.done_R14H, 0);
    expect_samp("t7 s2", 0, 1024, 1'b0, 1'b0);
    check("t7 count3", bus.count_R14U, 3);
    check("t7 done3", bus.done_R14H, 0);
    expect_samp("t7 s3", 1024, 1024, 1'b1, 1'b0);
    check("t7 done pulse", bus.done_R14H, 1);
    check("t7 valid off", bus.validSamp_R14H, 0);
    tick();
    check("t7 done clear", bus.done_R14H, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
